// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Constants, state encoding and parity helper shared by UART blocks.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_CLKS_PER_BIT = 217;  // 25 MHz / 115200 baud

    localparam int c_PAR_NONE = 0;
    localparam int c_PAR_ODD  = 1;
    localparam int c_PAR_EVEN = 2;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t c_ST_IDLE   = 3'd0;
    localparam rx_state_t c_ST_START  = 3'd1;
    localparam rx_state_t c_ST_DATA   = 3'd2;
    localparam rx_state_t c_ST_PARITY = 3'd3;
    localparam rx_state_t c_ST_STOP   = 3'd4;
    localparam rx_state_t c_ST_DONE   = 3'd5;

    // Data is zero-extended to 9 bits, so unused upper bits do not disturb the XOR.
    function automatic logic f_parity_bit(input logic [8:0] data, input int mode);
        logic x;
        x = ^data;
        case (mode)
            c_PAR_ODD:  return ~x;
            c_PAR_EVEN: return x;
            default:    return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_sync
// Purpose : 2-FF input synchroniser plus 3-sample majority voter around MID.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_rx,
    input  logic             i_active,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_mid,
    output logic             o_rxs,
    output logic             o_bit_val,
    output logic             o_bit_valid
);

    logic r_meta;
    logic r_sync;
    logic r_s0;
    logic r_s1;
    logic r_bit_val;
    logic r_bit_valid;
    logic w_maj;

    // Third vote is the live synchronised sample taken at cnt = MID+1.
    assign w_maj = (r_s0 & r_s1) | (r_s0 & r_sync) | (r_s1 & r_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta      <= 1'b1;
            r_sync      <= 1'b1;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_bit_val   <= 1'b1;
            r_bit_valid <= 1'b0;
        end else begin
            r_meta      <= i_rx;
            r_sync      <= r_meta;
            r_bit_valid <= 1'b0;
            if (i_active) begin
                if (i_cnt == i_mid - 1'b1) r_s0 <= r_sync;
                if (i_cnt == i_mid)        r_s1 <= r_sync;
                if (i_cnt == i_mid + 1'b1) begin
                    r_bit_val   <= w_maj;
                    r_bit_valid <= 1'b1;
                end
            end
        end
    end

    assign o_rxs       = r_sync;
    assign o_bit_val   = r_bit_val;
    assign o_bit_valid = r_bit_valid;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_param
// Purpose : Parametrised UART receiver (5..9 data bits, parity, 1/2 stop bits).
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = c_PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_Serial,
    output logic                 rx_DV_out,
    output logic [DATA_BITS-1:0] rx_Data_out,
    output logic                 rx_Parity_Err_out,
    output logic                 rx_Frame_Err_out,
    output logic                 rx_Busy_out
);

    localparam int c_MID   = CLKS_PER_BIT / 2;
    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(c_MID);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_hold;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 r_par_hold;
    logic                 r_frm_hold;
    logic                 w_rxs;
    logic                 w_bit_val;
    logic                 w_bit_valid;
    logic                 w_active;
    logic                 w_wrap;
    logic                 w_last_stop;

    assign w_active    = (r_state == c_ST_START) || (r_state == c_ST_DATA) ||
                         (r_state == c_ST_PARITY) || (r_state == c_ST_STOP);
    assign w_wrap      = (r_cnt == c_CNT_LAST);
    assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;

    uart_rx_sync #(
        .CNT_W(c_CNT_W)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rx       (rx_Serial),
        .i_active   (w_active),
        .i_cnt      (r_cnt),
        .i_mid      (c_CNT_MID),
        .o_rxs      (w_rxs),
        .o_bit_val  (w_bit_val),
        .o_bit_valid(w_bit_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // The final stop bit ends on its vote, not its wrap, so a following start edge is caught.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (!w_rxs) w_state_nxt = c_ST_START;
            c_ST_START: begin
                if (w_bit_valid && w_bit_val) w_state_nxt = c_ST_IDLE;
                else if (w_wrap)              w_state_nxt = c_ST_DATA;
            end
            c_ST_DATA:   if (w_wrap && (r_idx == c_IDX_LAST))
                             w_state_nxt = (PARITY_MODE != c_PAR_NONE) ? c_ST_PARITY : c_ST_STOP;
            c_ST_PARITY: if (w_wrap) w_state_nxt = c_ST_STOP;
            c_ST_STOP:   if (w_bit_valid && w_last_stop) w_state_nxt = c_ST_DONE;
            c_ST_DONE:   w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            r_data_hold <= '0;
            r_par_hold  <= 1'b0;
            r_frm_hold  <= 1'b0;
        end else begin
            if ((w_state_nxt != r_state) || w_wrap) r_cnt <= '0;
            else if (r_state != c_ST_IDLE)          r_cnt <= r_cnt + 1'b1;

            if (r_state == c_ST_IDLE) begin
                r_idx      <= '0;
                r_stop_idx <= 1'b0;
            end else if (w_wrap) begin
                if (r_state == c_ST_DATA) r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
                if (r_state == c_ST_STOP) r_stop_idx <= 1'b1;
            end

            if (w_bit_valid) begin
                case (r_state)
                    c_ST_DATA:   r_shift[r_idx] <= w_bit_val;
                    c_ST_PARITY: if (w_bit_val != f_parity_bit(9'(r_shift), PARITY_MODE))
                                     r_par_err <= 1'b1;
                    c_ST_STOP:   if (!w_bit_val) r_frm_err <= 1'b1;
                    default:     ;
                endcase
            end

            if (r_state == c_ST_DONE) begin
                r_data_hold <= r_shift;
                r_par_hold  <= r_par_err;
                r_frm_hold  <= r_frm_err;
                r_par_err   <= 1'b0;
                r_frm_err   <= 1'b0;
            end
        end
    end

    // In DONE the frame bypasses the hold registers so data is valid alongside DV.
    always_comb begin
        rx_DV_out         = 1'b0;
        rx_Data_out       = r_data_hold;
        rx_Parity_Err_out = r_par_hold;
        rx_Frame_Err_out  = r_frm_hold;
        rx_Busy_out       = w_active;
        if (r_state == c_ST_DONE) begin
            rx_DV_out         = 1'b1;
            rx_Data_out       = r_shift;
            rx_Parity_Err_out = r_par_err;
            rx_Frame_Err_out  = r_frm_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_param
// Purpose : Directed scoreboard bench: 8N1 default instance and 8E2 fast instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int c_A_CPB = 217;
    localparam int c_B_CPB = 16;
    localparam int c_PERIOD = 10;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        longint     t_fall;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic dv_a, perr_a, ferr_a, busy_a;
    logic dv_b, perr_b, ferr_b, busy_b;
    logic [7:0] data_a, data_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int total = 0;
    int bad = 0;
    int dv_cnt_a = 0, dv_cnt_b = 0, pushed_a = 0, pushed_b = 0;
    logic prev_busy_a = 1'b0, prev_busy_b = 1'b0;

    uart_rx_param #(.CLKS_PER_BIT(c_A_CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx_Serial(rx_a), .rx_DV_out(dv_a), .rx_Data_out(data_a),
        .rx_Parity_Err_out(perr_a), .rx_Frame_Err_out(ferr_a), .rx_Busy_out(busy_a));

    uart_rx_param #(.CLKS_PER_BIT(c_B_CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx_Serial(rx_b), .rx_DV_out(dv_b), .rx_Data_out(data_b),
        .rx_Parity_Err_out(perr_b), .rx_Frame_Err_out(ferr_b), .rx_Busy_out(busy_b));

    always #(c_PERIOD/2) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input exp_t e, input logic [7:0] d,
                               input logic pe, input logic fe, input logic bz, input logic pbz);
        int lat;
        lat = int'(($time - e.t_fall - c_PERIOD) / c_PERIOD);
        chk({tag, "_data"}, 32'(d), 32'(e.data));
        chk({tag, "_perr"}, 32'(pe), 32'(e.perr));
        chk({tag, "_ferr"}, 32'(fe), 32'(e.ferr));
        chk({tag, "_busy_on_dv"}, 32'(bz), 32'd0);
        chk({tag, "_busy_before_dv"}, 32'(pbz), 32'd1);
        chk({tag, "_latency_in_window"}, 32'((lat >= e.lat - 1) && (lat <= e.lat + 1)), 32'd1);
    endtask

    always @(negedge clk) begin
        if (dv_a) begin
            dv_cnt_a++;
            chk("a_dv_expected", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) check_frame("a", q_a.pop_front(), data_a, perr_a, ferr_a, busy_a, prev_busy_a);
        end
        prev_busy_a = busy_a;
    end

    always @(negedge clk) begin
        if (dv_b) begin
            dv_cnt_b++;
            chk("b_dv_expected", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) check_frame("b", q_b.pop_front(), data_b, perr_b, ferr_b, busy_b, prev_busy_b);
        end
        prev_busy_b = busy_b;
    end

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rx_a = v;
        else            rx_b = v;
        repeat (n) @(negedge clk);
    endtask

    // Instance a is 8N1 @217, instance b is 8E2 @16. A low final stop bit is released
    // shortly after its vote so the receiver does not see a fresh start edge.
    task automatic send(input int which, input logic [7:0] d, input logic par,
                        input logic stop_last, input int glitch_bit);
        int   cpb, mid, nstop, nbits;
        exp_t e;
        cpb   = (which == 0) ? c_A_CPB : c_B_CPB;
        mid   = cpb / 2;
        nstop = (which == 0) ? 1 : 2;
        nbits = 1 + 8 + ((which == 0) ? 0 : 1) + nstop;
        e.data   = d;
        e.perr   = (which == 0) ? 1'b0 : (par != ^d);
        e.ferr   = ~stop_last;
        e.t_fall = longint'($time);
        e.lat    = (nbits - 1) * cpb + mid + 1 + 4;
        if (which == 0) begin q_a.push_back(e); pushed_a++; end
        else            begin q_b.push_back(e); pushed_b++; end
        drive(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                drive(which, d[i], mid);
                drive(which, ~d[i], 1);
                drive(which, d[i], cpb - mid - 1);
            end else begin
                drive(which, d[i], cpb);
            end
        end
        if (which == 1) drive(which, par, cpb);
        for (int s = 0; s < nstop; s++) begin
            if ((s == nstop - 1) && !stop_last) begin
                drive(which, 1'b0, mid + 3);
                drive(which, 1'b1, cpb - mid - 3);
            end else begin
                drive(which, 1'b1, cpb);
            end
        end
    endtask

    task automatic wait_drain(input int which);
        int n;
        n = 0;
        while ((((which == 0) ? q_a.size() : q_b.size()) != 0) && (n < 4 * c_A_CPB)) begin
            @(negedge clk);
            n++;
        end
        chk((which == 0) ? "a_drain" : "b_drain", 32'((which == 0) ? q_a.size() : q_b.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_outs"}, 32'({dv_a, data_a, perr_a, ferr_a, busy_a}), 32'd0);
        chk({tag, "_b_outs"}, 32'({dv_b, data_b, perr_b, ferr_b, busy_b}), 32'd0);
    endtask

    initial begin
        logic [7:0] pat;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic 8N1 frame with latency and busy checks.
        send(0, 8'h3F, 1'b0, 1'b1, -1);
        wait_drain(0);
        chk("a_single_dv", 32'(dv_cnt_a), 32'd1);

        // Even parity, good and bad parity bit, then a low second stop bit.
        send(1, 8'hA5, 1'b0, 1'b1, -1);
        send(1, 8'hA5, 1'b1, 1'b1, -1);
        send(1, 8'h3C, 1'b0, 1'b0, -1);
        wait_drain(1);

        // Framing error then a clean frame.
        send(0, 8'h55, 1'b0, 1'b0, -1);
        send(0, 8'h12, 1'b0, 1'b1, -1);
        wait_drain(0);

        // False start: 50 clocks low is rejected before the start-bit vote.
        rx_a = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_busy_high", 32'(busy_a), 32'd1);
        repeat (30) @(negedge clk);
        rx_a = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_busy_low", 32'(busy_a), 32'd0);
        chk("glitch_no_dv", 32'(dv_cnt_a), 32'd3);

        // Single-clock spikes at mid-bit are outvoted.
        send(0, 8'h00, 1'b0, 1'b1, 3);
        send(0, 8'hFF, 1'b0, 1'b1, 3);
        wait_drain(0);

        // Back-to-back frames with no idle gap.
        send(0, 8'h55, 1'b0, 1'b1, -1);
        send(0, 8'hAA, 1'b0, 1'b1, -1);
        wait_drain(0);

        // Reset in the middle of data bit 4 of 0x3C: frame discarded.
        pat = 8'h3C;
        drive(0, 1'b0, c_A_CPB);
        for (int i = 0; i < 4; i++) drive(0, pat[i], c_A_CPB);
        rx_a = pat[4];
        repeat (100) @(negedge clk);
        chk("mid_frame_busy", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero("after_reset");
        send(0, 8'h81, 1'b0, 1'b1, -1);
        wait_drain(0);

        chk("a_dv_count", 32'(dv_cnt_a), 32'(pushed_a));
        chk("b_dv_count", 32'(dv_cnt_b), 32'(pushed_b));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(c_PERIOD * 60000);
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
